// File: rtl/serial_comparator_pkg.sv
// Shared types and elaboration helpers for the serial magnitude comparator.
package serial_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pair counter width: enough to hold WIDTH/2-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / 2);
        return (w < 1) ? 1 : w;
    endfunction

    // Operands are consumed two bits at a time, so the width must be even and non-trivial.
    function automatic bit width_ok(input int width);
        return (width >= 2) && ((width % 2) == 0);
    endfunction

endpackage

// File: rtl/cmp2_cell.sv
// Combinational 2-bit unsigned compare: gt = x > y, eq = x == y.
module cmp2_cell (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       gt,
    output logic       eq
);

    // Magnitude and equality of one bit pair.
    always_comb begin
        gt = (x > y);
        eq = (x == y);
    end

endmodule

// File: rtl/serial_comparator.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB-first,
// one bit pair per clock, and reports M = a > b and I = a == b.
// Optional build macro SERIAL_COMPARATOR_EARLY_EXIT_EN finishes as soon as
// the first differing pair is seen; results are identical either way.
//
// Handshake: start is sampled only in IDLE; the accepting edge latches a/b.
// busy is high while in RUN, done pulses for exactly one cycle in DONE, and
// M/I update only on entry to DONE and hold until the next completed compare.
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             M,
    output logic             I,
    output logic [1:0]       state_dbg
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH / 2 - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("serial_comparator: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             rm;
    logic             ri;
    logic             cm;
    logic             ci;
    logic             rm_next;
    logic             ri_next;
    logic             early_hit;
    logic             load;
    logic             step;
    logic             finish;

    cmp2_cell u_cell (
        .x  (sa[WIDTH-1:WIDTH-2]),
        .y  (sb[WIDTH-1:WIDTH-2]),
        .gt (cm),
        .eq (ci)
    );

    // Once a pair differs the verdict is frozen; lower pairs no longer matter.
    assign rm_next = ri ? cm : rm;
    assign ri_next = ri ? ci : ri;

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    assign early_hit = ri & ~ci;
`else
    assign early_hit = 1'b0;
`endif

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if ((cnt == '0) || early_hit) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand shifters, running flags, pair counter and held result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            rm  <= 1'b0;
            ri  <= 1'b1;
            M   <= 1'b0;
            I   <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            cnt <= CNT_INIT;
            rm  <= 1'b0;
            ri  <= 1'b1;
        end else if (step) begin
            sa  <= sa << 2;
            sb  <= sb << 2;
            cnt <= cnt - CW'(1);
            rm  <= rm_next;
            ri  <= ri_next;
            if (finish) begin
                M <= rm_next;
                I <= ri_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed vectors with hand-computed results,
// expected responses queued by the driver and checked by a done-driven monitor.
module tb_serial_comparator;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             M;
    logic             I;
    logic [1:0]       state_dbg;

    // Expected entry: {M, I, latency[5:0]}
    logic [7:0] exp_q[$];

    int n_vec;
    int n_fail;
    int bcnt;
    logic mdl_m;
    logic mdl_i;

    logic [1:0] cx;
    logic [1:0] cy;
    logic       cgt;
    logic       ceq;

    serial_comparator #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .M         (M),
        .I         (I),
        .state_dbg (state_dbg)
    );

    cmp2_cell u_cell_ut (
        .x  (cx),
        .y  (cy),
        .gt (cgt),
        .eq (ceq)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: pops an expectation on every done and checks held results each cycle.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset_n) begin
            bcnt  = 0;
            mdl_m = 1'b0;
            mdl_i = 1'b0;
        end else if (done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 M=%0b I=%0b, required no done", M, I);
            end else begin
                e = exp_q.pop_front();
                if ({M, I, 6'(bcnt)} !== e) begin
                    n_fail++;
                    $display("FAIL result: got M=%0b I=%0b lat=%0d, required M=%0b I=%0b lat=%0d",
                             M, I, bcnt, e[7], e[6], e[5:0]);
                end
                mdl_m = e[7];
                mdl_i = e[6];
            end
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end
        n_vec++;
        if ({M, I} !== {mdl_m, mdl_i}) begin
            n_fail++;
            $display("FAIL hold: got M=%0b I=%0b, required M=%0b I=%0b", M, I, mdl_m, mdl_i);
        end
    end

    function automatic logic [7:0] mk_exp(input logic m, input logic i,
                                          input int lat_plain, input int lat_early);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
        return {m, i, 6'(lat_early)};
`else
        return {m, i, 6'(lat_plain)};
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] req);
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, req);
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout_%s: got no done in 40 cycles, required done", tag);
        end
    endtask

    // Driver: one accepted compare, then wait for completion and the return to IDLE.
    task automatic do_cmp(input logic [7:0] va, input logic [7:0] vb, input logic m,
                          input logic i, input int lp, input int le);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(posedge clk);
        exp_q.push_back(mk_exp(m, i, lp, le));
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom_range(0, 255));
        b     = 8'($urandom_range(0, 255));
        wait_done("cmp");
        @(posedge clk);
    endtask

    // Stimulus
    initial begin
        logic [15:0] gt_tab;
        logic [15:0] eq_tab;
        n_vec   = 0;
        n_fail  = 0;
        bcnt    = 0;
        mdl_m   = 1'b0;
        mdl_i   = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        cx      = '0;
        cy      = '0;

        // Cell unit test: index {x, y}; gt at 4,8,9,12,13,14; eq on the diagonal.
        gt_tab = 16'h7310;
        eq_tab = 16'h8421;
        for (int n = 0; n < 16; n++) begin
            cx = 2'(n >> 2);
            cy = 2'(n);
            #1;
            check("cell", {6'd0, cgt, ceq}, {6'd0, gt_tab[n], eq_tab[n]});
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", {4'd0, busy, done, M, I}, 8'h00);
        check("reset_state", {6'd0, state_dbg}, 8'h00);
        #1 reset_n = 1'b1;

        do_cmp(8'h00, 8'h00, 1'b0, 1'b1, 4, 4);
        do_cmp(8'hA5, 8'hA4, 1'b1, 1'b0, 4, 4);
        do_cmp(8'hA4, 8'hA5, 1'b0, 1'b0, 4, 4);
        repeat (10) @(negedge clk);
        do_cmp(8'h80, 8'h7F, 1'b1, 1'b0, 4, 1);

        // start held through RUN/DONE with operands changed after acceptance
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(posedge clk);
        exp_q.push_back(mk_exp(1'b0, 1'b0, 4, 2));
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        wait_done("held1");
        @(posedge clk);
        @(posedge clk);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 4, 1));
        @(negedge clk);
        start = 1'b0;
        wait_done("held2");
        @(posedge clk);

        // Reset mid-RUN after E2
        do_cmp(8'hC3, 8'hC2, 1'b1, 1'b0, 4, 4);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h55;
        @(posedge clk);
        exp_q.push_back(mk_exp(1'b0, 1'b1, 4, 4));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", {4'd0, busy, done, M, I}, 8'h00);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_state", {6'd0, state_dbg}, 8'h00);
        do_cmp(8'h3C, 8'h3C, 1'b0, 1'b1, 4, 4);

        do_cmp(8'h01, 8'h02, 1'b0, 1'b0, 4, 4);
        do_cmp(8'hFF, 8'hFE, 1'b1, 1'b0, 4, 4);
        do_cmp(8'h40, 8'h80, 1'b0, 1'b0, 4, 1);
        do_cmp(8'h2B, 8'h27, 1'b1, 1'b0, 4, 3);
        do_cmp(8'h00, 8'hFF, 1'b0, 1'b0, 4, 1);
        do_cmp(8'h96, 8'h96, 1'b0, 1'b1, 4, 4);

        repeat (3) @(negedge clk);
        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
